csr_unit: RTL and testbench

- Machine-mode CSR file for the npc core; successor to the four-register CSR block.
- Parametrised for RV32/RV64. Adds csrrw/csrrs/csrrc semantics, trap entry and mret sequencing, mie/mip interrupt gating, vectored mtvec, mscratch, and 64-bit mcycle/minstret counters.
- Sits beside the execute stage. Supplies CSR read data, illegal-access flags, and redirect PC/valid to the fetch stage.

---
 rtl/csr_unit.sv | 195 +++++++++++++++++++
 tb/tb_csr_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// Machine-mode CSR file: csrrw/csrrs/csrrc access, trap entry and mret
// sequencing, interrupt gating, vectored mtvec and 64-bit counters.
module csr_unit #(
  parameter int DATA_LEN    = 32,
  parameter bit VECTORED_EN = 1'b1,
  parameter bit COUNTER_EN  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          csr_op,
  input  logic [11:0]         addr,
  input  logic [DATA_LEN-1:0] wdata,
  output logic [DATA_LEN-1:0] rdata,
  output logic                illegal,
  input  logic                trap_valid,
  input  logic [DATA_LEN-1:0] trap_cause,
  input  logic [DATA_LEN-1:0] trap_pc,
  input  logic                mret,
  input  logic                instret_inc,
  input  logic                irq_timer,
  input  logic                irq_ext,
  output logic                irq_req,
  output logic [DATA_LEN-1:0] irq_cause,
  output logic                redirect_valid,
  output logic [DATA_LEN-1:0] redirect_pc
);

  localparam logic [63:0] MSTATUS_RST64 = (DATA_LEN == 64) ? 64'h0000_0000_A000_1800
                                                           : 64'h0000_0000_0000_1800;
  localparam logic [DATA_LEN-1:0] MSTATUS_BASE = MSTATUS_RST64[DATA_LEN-1:0];
  localparam logic [DATA_LEN-1:0] ZERO         = {DATA_LEN{1'b0}};
  localparam logic [DATA_LEN-1:0] LOW2_MASK    = {{(DATA_LEN-2){1'b1}}, 2'b00};
  localparam logic [DATA_LEN-1:0] MTVEC_MASK   = {{(DATA_LEN-2){1'b1}}, 1'b0, VECTORED_EN};

  // Architectural state; mstatus keeps only its two writable bits.
  logic                mie_bit_r, mpie_r, mtie_r, meie_r;
  logic [DATA_LEN-1:0] mtvec_r, mscratch_r, mepc_r, mcause_r;
  logic [63:0]         mcycle_r, minstret_r;

  logic [DATA_LEN-1:0] mstatus_s, mie_s, mip_s, old_s, new_s;
  logic                mapped_s, ro_s, write_req_s, illegal_s, do_write_s;
  logic                ext_pend_s, tmr_pend_s;
  logic [63:0]         mcycle_nx_s, minstret_nx_s;

  // Next counter value: a CSR write beats the increment; a high-half write
  // lets the low half keep counting but never carries into the new high half.
  function automatic logic [63:0] counter_next(input logic [63:0]         cur,
                                               input logic                inc,
                                               input logic                wr_lo,
                                               input logic                wr_hi,
                                               input logic [DATA_LEN-1:0] val);
    logic [63:0] nxt;
    if (wr_lo) begin
      if (DATA_LEN == 64) nxt = 64'(val);
      else                nxt = {cur[63:32], val[31:0]};
    end else if (wr_hi) begin
      nxt = {val[31:0], cur[31:0] + {31'd0, inc}};
    end else begin
      nxt = cur + {63'd0, inc};
    end
    return nxt;
  endfunction

  // Assemble the read views of the composite registers.
  always_comb begin
    mstatus_s     = MSTATUS_BASE;
    mstatus_s[3]  = mie_bit_r;
    mstatus_s[7]  = mpie_r;
    mie_s         = ZERO;
    mie_s[7]      = mtie_r;
    mie_s[11]     = meie_r;
    mip_s         = ZERO;
    mip_s[7]      = irq_timer;
    mip_s[11]     = irq_ext;
  end

  // Address decode: legality, read-only flag and the current (old) value.
  always_comb begin
    mapped_s = 1'b0;
    ro_s     = 1'b0;
    old_s    = ZERO;
    case (addr)
      12'h300: begin mapped_s = 1'b1; old_s = mstatus_s;  end
      12'h304: begin mapped_s = 1'b1; old_s = mie_s;      end
      12'h305: begin mapped_s = 1'b1; old_s = mtvec_r;    end
      12'h340: begin mapped_s = 1'b1; old_s = mscratch_r; end
      12'h341: begin mapped_s = 1'b1; old_s = mepc_r;     end
      12'h342: begin mapped_s = 1'b1; old_s = mcause_r;   end
      12'h344: begin mapped_s = 1'b1; ro_s = 1'b1; old_s = mip_s; end
      12'hF14: begin mapped_s = 1'b1; ro_s = 1'b1; old_s = ZERO;  end
      12'hB00: begin mapped_s = COUNTER_EN; old_s = mcycle_r[DATA_LEN-1:0];   end
      12'hB02: begin mapped_s = COUNTER_EN; old_s = minstret_r[DATA_LEN-1:0]; end
      12'hB80: begin
        mapped_s = COUNTER_EN && (DATA_LEN == 32);
        old_s    = DATA_LEN'(mcycle_r[63:32]);
      end
      12'hB82: begin
        mapped_s = COUNTER_EN && (DATA_LEN == 32);
        old_s    = DATA_LEN'(minstret_r[63:32]);
      end
      default: begin mapped_s = 1'b0; ro_s = 1'b0; old_s = ZERO; end
    endcase
  end

  // Access control, read-modify-write value and read data.
  always_comb begin
    write_req_s = (csr_op == 2'b01) || (wdata != ZERO);
    illegal_s   = (csr_op != 2'b00) && (!mapped_s || (ro_s && write_req_s));
    do_write_s  = (csr_op != 2'b00) && !illegal_s && write_req_s && !trap_valid && !mret;
    case (csr_op)
      2'b01:   new_s = wdata;
      2'b10:   new_s = old_s | wdata;
      2'b11:   new_s = old_s & ~wdata;
      default: new_s = old_s;
    endcase
    if ((csr_op != 2'b00) && !illegal_s) rdata = old_s;
    else                                 rdata = ZERO;
    illegal = illegal_s;
  end

  // Interrupt gating; external interrupt outranks the timer.
  always_comb begin
    ext_pend_s = meie_r & irq_ext;
    tmr_pend_s = mtie_r & irq_timer;
    irq_req    = mie_bit_r & (ext_pend_s | tmr_pend_s);
    if (ext_pend_s) irq_cause = {1'b1, {(DATA_LEN-5){1'b0}}, 4'hB};
    else            irq_cause = {1'b1, {(DATA_LEN-5){1'b0}}, 4'h7};
  end

  // Fetch redirect: trap vector (vectored for interrupts) or mepc on mret.
  always_comb begin
    redirect_valid = trap_valid | mret;
    if (trap_valid) begin
      if (mtvec_r[0] && trap_cause[DATA_LEN-1])
        redirect_pc = (mtvec_r & LOW2_MASK) + (trap_cause << 2'd2);
      else
        redirect_pc = mtvec_r & LOW2_MASK;
    end else if (mret) begin
      redirect_pc = mepc_r;
    end else begin
      redirect_pc = ZERO;
    end
  end

  // Counter next-state values.
  always_comb begin
    mcycle_nx_s   = counter_next(mcycle_r, 1'b1,
                                 do_write_s && (addr == 12'hB00),
                                 do_write_s && (addr == 12'hB80), new_s);
    minstret_nx_s = counter_next(minstret_r, instret_inc,
                                 do_write_s && (addr == 12'hB02),
                                 do_write_s && (addr == 12'hB82), new_s);
  end

  // State update: reset > trap entry > mret > CSR write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mie_bit_r  <= 1'b0;
      mpie_r     <= 1'b0;
      mtie_r     <= 1'b0;
      meie_r     <= 1'b0;
      mtvec_r    <= ZERO;
      mscratch_r <= ZERO;
      mepc_r     <= ZERO;
      mcause_r   <= ZERO;
      mcycle_r   <= 64'd0;
      minstret_r <= 64'd0;
    end else begin
      mcycle_r   <= mcycle_nx_s;
      minstret_r <= minstret_nx_s;
      if (trap_valid) begin
        mepc_r    <= trap_pc & LOW2_MASK;
        mcause_r  <= trap_cause;
        mpie_r    <= mie_bit_r;
        mie_bit_r <= 1'b0;
      end else if (mret) begin
        mie_bit_r <= mpie_r;
        mpie_r    <= 1'b1;
      end else if (do_write_s) begin
        case (addr)
          12'h300: begin mie_bit_r <= new_s[3]; mpie_r <= new_s[7];  end
          12'h304: begin mtie_r    <= new_s[7]; meie_r <= new_s[11]; end
          12'h305: mtvec_r    <= new_s & MTVEC_MASK;
          12'h340: mscratch_r <= new_s;
          12'h341: mepc_r     <= new_s & LOW2_MASK;
          12'h342: mcause_r   <= new_s;
          default: mcause_r   <= mcause_r;
        endcase
      end else begin
        mcause_r <= mcause_r;
      end
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit (DATA_LEN=32, all features on).
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  csr_op;
  logic [11:0] addr;
  logic [31:0] wdata, rdata;
  logic        illegal;
  logic        trap_valid;
  logic [31:0] trap_cause, trap_pc;
  logic        mret, instret_inc, irq_timer, irq_ext;
  logic        irq_req;
  logic [31:0] irq_cause;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  csr_unit #(.DATA_LEN(32), .VECTORED_EN(1'b1), .COUNTER_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .csr_op(csr_op), .addr(addr), .wdata(wdata),
    .rdata(rdata), .illegal(illegal), .trap_valid(trap_valid),
    .trap_cause(trap_cause), .trap_pc(trap_pc), .mret(mret),
    .instret_inc(instret_inc), .irq_timer(irq_timer), .irq_ext(irq_ext),
    .irq_req(irq_req), .irq_cause(irq_cause), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  task automatic set_csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
    csr_op = op; addr = a; wdata = wd;
    #2;
  endtask

  // Advance one clock, then return pulse-type inputs to idle.
  task automatic step();
    @(posedge clk); #1;
    csr_op = 2'b00; addr = 12'h000; wdata = 32'h0;
    trap_valid = 1'b0; trap_cause = 32'h0; trap_pc = 32'h0;
    mret = 1'b0; instret_inc = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; irq_timer = 1'b0; irq_ext = 1'b0;
    csr_op = 2'b00; addr = 12'h000; wdata = 32'h0;
    trap_valid = 1'b0; trap_cause = 32'h0; trap_pc = 32'h0; mret = 1'b0; instret_inc = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    set_csr(2'b10, 12'h300, 32'h0);
    checks++; if (rdata !== 32'h0000_1800) begin failures++; $display("FAIL reset_mstatus got=%h exp=%h", rdata, 32'h0000_1800); end
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
    checks++; if (redirect_valid !== 1'b0 || irq_req !== 1'b0) begin failures++; $display("FAIL reset_outputs got=%b%b exp=00", redirect_valid, irq_req); end
    step();
    set_csr(2'b10, 12'hB00, 32'h0);
    checks++; if (rdata !== 32'h1) begin failures++; $display("FAIL reset_mcycle got=%h exp=%h", rdata, 32'h1); end
    step();
  endtask

  task automatic test_csr_ops();
    set_csr(2'b01, 12'h340, 32'hA5A5_A5A5);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL op_write_old got=%h exp=%h", rdata, 32'h0); end
    step();
    set_csr(2'b10, 12'h340, 32'h0000_000F);
    checks++; if (rdata !== 32'hA5A5_A5A5) begin failures++; $display("FAIL op_after_write got=%h exp=%h", rdata, 32'hA5A5_A5A5); end
    step();
    set_csr(2'b11, 12'h340, 32'hA000_0000);
    checks++; if (rdata !== 32'hA5A5_A5AF) begin failures++; $display("FAIL op_after_set got=%h exp=%h", rdata, 32'hA5A5_A5AF); end
    step();
    set_csr(2'b10, 12'h340, 32'h0);
    checks++; if (rdata !== 32'h05A5_A5AF) begin failures++; $display("FAIL op_after_clear got=%h exp=%h", rdata, 32'h05A5_A5AF); end
    step();
    set_csr(2'b00, 12'h340, 32'h1234_5678);
    checks++; if (rdata !== 32'h0 || illegal !== 1'b0) begin failures++; $display("FAIL op_none got=%h/%b exp=0/0", rdata, illegal); end
    step();
    set_csr(2'b10, 12'h340, 32'h0);
    checks++; if (rdata !== 32'h05A5_A5AF) begin failures++; $display("FAIL op_none_nowrite got=%h exp=%h", rdata, 32'h05A5_A5AF); end
    step();
  endtask

  task automatic test_illegal();
    set_csr(2'b01, 12'h344, 32'h0000_0080);
    checks++; if (illegal !== 1'b1 || rdata !== 32'h0) begin failures++; $display("FAIL ill_mip_write got=%b/%h exp=1/0", illegal, rdata); end
    step();
    set_csr(2'b10, 12'h344, 32'h0);
    checks++; if (illegal !== 1'b0 || rdata !== 32'h0) begin failures++; $display("FAIL ill_mip_read got=%b/%h exp=0/0", illegal, rdata); end
    step();
    set_csr(2'b10, 12'h7C0, 32'h0);
    checks++; if (illegal !== 1'b1 || rdata !== 32'h0) begin failures++; $display("FAIL ill_unmapped got=%b/%h exp=1/0", illegal, rdata); end
    step();
    set_csr(2'b10, 12'hF14, 32'h0);
    checks++; if (illegal !== 1'b0 || rdata !== 32'h0) begin failures++; $display("FAIL ill_hartid_read got=%b/%h exp=0/0", illegal, rdata); end
    step();
    set_csr(2'b11, 12'hF14, 32'h0000_0001);
    checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL ill_hartid_clear got=%b exp=1", illegal); end
    step();
  endtask

  task automatic test_vectored_trap();
    set_csr(2'b01, 12'h305, 32'h8000_0003);
    step();
    set_csr(2'b10, 12'h305, 32'h0);
    checks++; if (rdata !== 32'h8000_0001) begin failures++; $display("FAIL trap_mtvec_warl got=%h exp=%h", rdata, 32'h8000_0001); end
    step();
    set_csr(2'b01, 12'h300, 32'h0000_0008);
    step();
    trap_valid = 1'b1; trap_cause = 32'h8000_0007; trap_pc = 32'h8000_0123;
    set_csr(2'b10, 12'h300, 32'h0);
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_001C) begin failures++; $display("FAIL trap_vector got=%b/%h exp=1/%h", redirect_valid, redirect_pc, 32'h8000_001C); end
    checks++; if (rdata !== 32'h0000_1808) begin failures++; $display("FAIL trap_same_cycle_read got=%h exp=%h", rdata, 32'h0000_1808); end
    step();
    set_csr(2'b10, 12'h341, 32'h0);
    checks++; if (rdata !== 32'h8000_0120) begin failures++; $display("FAIL trap_mepc got=%h exp=%h", rdata, 32'h8000_0120); end
    step();
    set_csr(2'b10, 12'h300, 32'h0);
    checks++; if (rdata !== 32'h0000_1880) begin failures++; $display("FAIL trap_mstatus got=%h exp=%h", rdata, 32'h0000_1880); end
    step();
    set_csr(2'b10, 12'h342, 32'h0);
    checks++; if (rdata !== 32'h8000_0007) begin failures++; $display("FAIL trap_mcause got=%h exp=%h", rdata, 32'h8000_0007); end
    step();
    mret = 1'b1;
    #2;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0120) begin failures++; $display("FAIL mret_redirect got=%b/%h exp=1/%h", redirect_valid, redirect_pc, 32'h8000_0120); end
    step();
    set_csr(2'b10, 12'h300, 32'h0);
    checks++; if (rdata !== 32'h0000_1888) begin failures++; $display("FAIL mret_mstatus got=%h exp=%h", rdata, 32'h0000_1888); end
    step();
    trap_valid = 1'b1; trap_cause = 32'h0000_0002; trap_pc = 32'h0000_0100;
    #2;
    checks++; if (redirect_pc !== 32'h8000_0000) begin failures++; $display("FAIL trap_sync_base got=%h exp=%h", redirect_pc, 32'h8000_0000); end
    step();
  endtask

  task automatic test_interrupts();
    set_csr(2'b01, 12'h304, 32'hFFFF_FFFF);
    step();
    irq_timer = 1'b1; irq_ext = 1'b1;
    set_csr(2'b10, 12'h304, 32'h0);
    checks++; if (rdata !== 32'h0000_0880) begin failures++; $display("FAIL irq_mie_warl got=%h exp=%h", rdata, 32'h0000_0880); end
    checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL irq_gated_by_mie got=%b exp=0", irq_req); end
    step();
    set_csr(2'b01, 12'h300, 32'h0000_0008);
    step();
    set_csr(2'b10, 12'h344, 32'h0);
    checks++; if (irq_req !== 1'b1 || irq_cause !== 32'h8000_000B) begin failures++; $display("FAIL irq_ext_prio got=%b/%h exp=1/%h", irq_req, irq_cause, 32'h8000_000B); end
    checks++; if (rdata !== 32'h0000_0880) begin failures++; $display("FAIL irq_mip got=%h exp=%h", rdata, 32'h0000_0880); end
    step();
    irq_ext = 1'b0;
    #2;
    checks++; if (irq_req !== 1'b1 || irq_cause !== 32'h8000_0007) begin failures++; $display("FAIL irq_timer got=%b/%h exp=1/%h", irq_req, irq_cause, 32'h8000_0007); end
    set_csr(2'b11, 12'h300, 32'h0000_0008);
    step();
    #2;
    checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL irq_mie_cleared got=%b exp=0", irq_req); end
    irq_timer = 1'b0;
  endtask

  task automatic test_counters();
    set_csr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    step();
    set_csr(2'b10, 12'hB00, 32'h0);
    checks++; if (rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL cnt_written_low got=%h exp=%h", rdata, 32'hFFFF_FFFF); end
    step();
    set_csr(2'b10, 12'hB00, 32'h0);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL cnt_low_wrap got=%h exp=%h", rdata, 32'h0); end
    step();
    set_csr(2'b10, 12'hB80, 32'h0);
    checks++; if (rdata !== 32'h1) begin failures++; $display("FAIL cnt_high_carry got=%h exp=%h", rdata, 32'h1); end
    step();
    set_csr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    step();
    set_csr(2'b01, 12'hB80, 32'h0000_0010);
    checks++; if (rdata !== 32'h1) begin failures++; $display("FAIL cnt_high_old got=%h exp=%h", rdata, 32'h1); end
    step();
    set_csr(2'b10, 12'hB00, 32'h0);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL cnt_low_after_hiwr got=%h exp=%h", rdata, 32'h0); end
    step();
    set_csr(2'b10, 12'hB80, 32'h0);
    checks++; if (rdata !== 32'h0000_0010) begin failures++; $display("FAIL cnt_no_carry got=%h exp=%h", rdata, 32'h0000_0010); end
    step();
    instret_inc = 1'b1;
    set_csr(2'b01, 12'hB02, 32'h0000_0005);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL instret_start got=%h exp=%h", rdata, 32'h0); end
    step();
    instret_inc = 1'b1;
    set_csr(2'b10, 12'hB02, 32'h0);
    checks++; if (rdata !== 32'h5) begin failures++; $display("FAIL instret_write_wins got=%h exp=%h", rdata, 32'h5); end
    step();
    set_csr(2'b10, 12'hB02, 32'h0);
    checks++; if (rdata !== 32'h6) begin failures++; $display("FAIL instret_inc got=%h exp=%h", rdata, 32'h6); end
    step();
    set_csr(2'b10, 12'hB02, 32'h0);
    checks++; if (rdata !== 32'h6) begin failures++; $display("FAIL instret_hold got=%h exp=%h", rdata, 32'h6); end
    step();
  endtask

  task automatic test_back_to_back();
    trap_valid = 1'b1; trap_cause = 32'h0000_000B; trap_pc = 32'h0000_0200;
    set_csr(2'b01, 12'h300, 32'h0000_0088);
    checks++; if (rdata !== 32'h0000_1800) begin failures++; $display("FAIL b2b_pre_edge got=%h exp=%h", rdata, 32'h0000_1800); end
    step();
    set_csr(2'b10, 12'h300, 32'h0);
    checks++; if (rdata !== 32'h0000_1800) begin failures++; $display("FAIL b2b_trap_wins got=%h exp=%h", rdata, 32'h0000_1800); end
    step();
    set_csr(2'b10, 12'h341, 32'h0);
    checks++; if (rdata !== 32'h0000_0200) begin failures++; $display("FAIL b2b_mepc got=%h exp=%h", rdata, 32'h0000_0200); end
    step();
    mret = 1'b1;
    set_csr(2'b01, 12'h340, 32'h0000_1234);
    step();
    set_csr(2'b10, 12'h340, 32'h0);
    checks++; if (rdata !== 32'h05A5_A5AF) begin failures++; $display("FAIL b2b_mret_wins got=%h exp=%h", rdata, 32'h05A5_A5AF); end
    step();
    set_csr(2'b10, 12'h300, 32'h0);
    checks++; if (rdata !== 32'h0000_1880) begin failures++; $display("FAIL b2b_mret_mstatus got=%h exp=%h", rdata, 32'h0000_1880); end
    step();
  endtask

  task automatic test_reset_wins();
    rst = 1'b1; trap_valid = 1'b1; trap_cause = 32'h8000_0007; trap_pc = 32'h0000_0400;
    set_csr(2'b01, 12'h340, 32'h0000_FFFF);
    step();
    rst = 1'b0;
    set_csr(2'b10, 12'hB00, 32'h0);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rstw_mcycle got=%h exp=%h", rdata, 32'h0); end
    step();
    set_csr(2'b10, 12'h340, 32'h0);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rstw_mscratch got=%h exp=%h", rdata, 32'h0); end
    step();
    set_csr(2'b10, 12'h341, 32'h0);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rstw_mepc got=%h exp=%h", rdata, 32'h0); end
    step();
    set_csr(2'b10, 12'h300, 32'h0);
    checks++; if (rdata !== 32'h0000_1800) begin failures++; $display("FAIL rstw_mstatus got=%h exp=%h", rdata, 32'h0000_1800); end
    step();
  endtask

  initial begin
    test_reset();
    test_csr_ops();
    test_illegal();
    test_vectored_trap();
    test_interrupts();
    test_counters();
    test_back_to_back();
    test_reset_wins();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
